// File: rtl/spawn_arb_pkg.sv
// rtl/spawn_arb_pkg.sv - shared types and constants for the spawn arbiter
//
// Purpose: FSM state encoding, requester count and grant-id width, plus a
// one-hot decode helper used when a granted request is retired.
// Ports: none (package).

package spawn_arb_pkg;

  localparam int N_REQ_DEF = 8;
  localparam int ID_W      = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  function automatic logic [N_REQ_DEF-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ_DEF-1:0] one;
    one = {{(N_REQ_DEF-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/spawn_arbiter_rr_pick.sv
// rtl/spawn_arbiter_rr_pick.sv - combinational round-robin requester picker
//
// Purpose: selects the first set pending bit searching upward from
// (last_id + 1) mod 8, wrapping through 7 to 0.
// Ports:
//   pending [7:0] in  - latched outstanding requests
//   last_id [2:0] in  - most recently granted requester
//   id      [2:0] out - selected requester (valid when found=1)
//   found         out - at least one pending bit is set

module rr_pick
  import spawn_arb_pkg::*;
(
  input  logic [N_REQ_DEF-1:0] pending,
  input  logic [ID_W-1:0]      last_id,
  output logic [ID_W-1:0]      id,
  output logic                 found
);

  logic [ID_W-1:0]      start;
  logic [ID_W-1:0]      enc;
  logic [N_REQ_DEF-1:0] rot;

  always_comb begin
    start = last_id + ID_W'(1);

    // Rotate so the search start lands on bit 0; 3-bit index wraps mod 8.
    rot = '0;
    for (int i = 0; i < N_REQ_DEF; i++) begin
      rot[i] = pending[start + ID_W'(i)];
    end

    // Lowest set bit wins: scan downward so the last hit is the lowest.
    enc = '0;
    for (int i = N_REQ_DEF - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = ID_W'(i);
      end
    end

    found = |rot;
    id    = start + enc;
  end

endmodule

// File: rtl/spawn_arbiter.sv
// rtl/spawn_arbiter.sv - round-robin spawn arbiter with optional frame cooldown
//
// Purpose: latches rising edges of debounced button requests, grants one
// requester at a time round-robin to a shared spawn resource, and (when
// SPAWN_ARB_COOLDOWN_EN is defined) waits COOLDOWN_FRAMES frame ticks after
// each accepted grant before issuing the next one.
// Configuration macro: SPAWN_ARB_COOLDOWN_EN (undefined: no cooldown state).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   frame_tick        - one-cycle pulse per video frame
//   req [7:0]         - level requests, one bit per requester
//   enable            - gates IDLE->GRANT only
//   grant_ready       - resource accepts the presented grant
//   grant_valid       - grant presented
//   grant_id [2:0]    - granted requester
//   busy              - in GRANT or COOLDOWN
//   pending [7:0]     - latched outstanding requests

module spawn_arbiter
  import spawn_arb_pkg::*;
#(
  parameter int N_REQ           = N_REQ_DEF,
  parameter int COOLDOWN_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending
);

  state_e           state_q;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clear;
  logic             armed_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  last_id_q;
  logic             grant_valid_q;
  logic             busy_q;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;
  logic             handshake;

`ifdef SPAWN_ARB_COOLDOWN_EN
  logic [3:0]       cnt_q;
`else
  logic             unused_cfg;
  assign unused_cfg = frame_tick ^ (COOLDOWN_FRAMES != 0);
`endif

  rr_pick u_rr_pick (
    .pending (pending_q),
    .last_id (last_id_q),
    .id      (pick_id),
    .found   (pick_found)
  );

  assign handshake = grant_valid_q & grant_ready;

  always_comb begin
    // armed_q is low for the first edge after reset so that buttons held
    // through reset are only sampled, not reported as fresh presses.
    rise      = req & ~req_q & {N_REQ{armed_q}};
    clear     = handshake ? onehot(grant_id_q) : '0;
    // A new press on the bit being retired survives the clear.
    pending_d = (pending_q & ~clear) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_q         <= '0;
      armed_q       <= 1'b0;
      pending_q     <= '0;
      grant_id_q    <= '0;
      last_id_q     <= '1;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SPAWN_ARB_COOLDOWN_EN
      cnt_q         <= '0;
`endif
    end else begin
      req_q     <= req;
      armed_q   <= 1'b1;
      pending_q <= pending_d;

      case (state_q)
        IDLE: begin
          if (enable && pick_found) begin
            state_q       <= GRANT;
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end

        GRANT: begin
          if (grant_ready) begin
            last_id_q     <= grant_id_q;
            grant_valid_q <= 1'b0;
`ifdef SPAWN_ARB_COOLDOWN_EN
            if (COOLDOWN_FRAMES == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= COOLDOWN;
              cnt_q   <= 4'(COOLDOWN_FRAMES);
            end
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end

`ifdef SPAWN_ARB_COOLDOWN_EN
        COOLDOWN: begin
          if (frame_tick) begin
            // Leave on the last tick; <= 1 also keeps the counter off zero-wrap.
            if (cnt_q <= 4'd1) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
`endif

        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_spawn_arbiter.sv
// tb/tb_spawn_arbiter.sv - scoreboard testbench for spawn_arbiter

module tb_spawn_arbiter;

  localparam int CDF = 3;
`ifdef SPAWN_ARB_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] req = '0;
  logic       enable = 1'b0;
  logic       grant_ready = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       busy;
  logic [7:0] pending;

  spawn_arbiter #(.N_REQ(8), .COOLDOWN_FRAMES(CDF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .req         (req),
    .enable      (enable),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int obs_grants = 0;
  bit mon_en = 1'b0;
  int unsigned exp_q[$];

  // Reference model: pending set, mode 0=idle 1=presenting 2=cooling.
  logic [7:0] m_pend;
  logic [7:0] m_req_prev;
  bit         m_armed;
  int         m_mode;
  int         m_frames;
  int         m_last;
  int         m_gid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] p, input int last);
    for (int off = 1; off <= 8; off++) begin
      if (p[(last + off) % 8]) return (last + off) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_req_prev = '0; m_armed = 1'b0;
    m_mode = 0; m_frames = 0; m_last = 7; m_gid = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [7:0] nxt;
    nxt = m_pend;
    if (m_mode == 1 && grant_ready) nxt[m_gid] = 1'b0;
    if (m_armed) nxt = nxt | (req & ~m_req_prev);
    case (m_mode)
      0: if (enable && m_pend != 0) begin
           m_gid = pick(m_pend, m_last);
           m_mode = 1;
           exp_q.push_back(m_gid);
         end
      1: if (grant_ready) begin
           m_last = m_gid;
           if (CD_EN && CDF > 0) begin m_mode = 2; m_frames = CDF; end
           else m_mode = 0;
         end
      default: if (frame_tick) begin
           m_frames--;
           if (m_frames == 0) m_mode = 0;
         end
    endcase
    m_pend = nxt;
    m_req_prev = req;
    m_armed = 1'b1;
  endtask

  // Applies inputs, advances one edge, returns 1 time unit after the edge.
  task automatic step(input logic [7:0] r, input bit en, input bit rdy, input bit ft);
    req = r; enable = en; grant_ready = rdy; frame_tick = ft;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    mon_en = 1'b0;
    req = r; enable = 1'b0; grant_ready = 1'b0; frame_tick = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic run_until_valid(input logic [7:0] r, input bit ft, input int budget);
    int n;
    n = 0;
    while (!grant_valid && n < budget) begin
      step(r, 1'b1, 1'b0, ft);
      n++;
    end
    check("wait_valid_timeout", grant_valid, 1);
  endtask

  task automatic wait_idle(input logic [7:0] r);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step(r, 1'b1, 1'b1, 1'b1);
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  // Monitor: compares against the model each cycle and pops the scoreboard
  // whenever a new grant appears.
  initial begin
    bit         prev_v;
    logic [2:0] prev_id;
    prev_v = 1'b0;
    prev_id = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_v = 1'b0;
        continue;
      end
      check("pending", pending, m_pend);
      check("busy", busy, m_mode != 0);
      check("grant_valid", grant_valid, m_mode == 1);
      if (grant_valid && !prev_v) begin
        obs_grants++;
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1, 0);
        end else begin
          check("grant_id", grant_id, exp_q.pop_front());
        end
      end else if (grant_valid && prev_v) begin
        check("grant_id_stable", grant_id, prev_id);
      end
      prev_v = grant_valid;
      prev_id = grant_id;
    end
  end

  initial begin
    logic [7:0] r;
    int n;

    // Reset with all buttons held; held buttons must not arm after release.
    do_reset(8'hFF);
    repeat (3) step(8'hFF, 1'b1, 1'b1, 1'b0);
    check("held_no_pending", pending, 0);
    check("held_no_grant", grant_valid, 0);

    // Single rise: pending after edge k, grant after k+1, cleared after k+2.
    do_reset(8'h00);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    step(8'h08, 1'b1, 1'b1, 1'b0);
    check("lat_pending_set", pending, 8'h08);
    check("lat_not_yet_valid", grant_valid, 0);
    step(8'h08, 1'b1, 1'b1, 1'b0);
    check("lat_valid", grant_valid, 1);
    check("lat_id", grant_id, 3);
    step(8'h08, 1'b1, 1'b1, 1'b0);
    check("lat_pending_clr", pending[3], 0);
    check("lat_valid_drop", grant_valid, 0);
    wait_idle(8'h08);

    // Simultaneous 0 and 5: 0 first, then 5, then a re-press of 0 wins.
    do_reset(8'h00);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    step(8'h21, 1'b1, 1'b1, 1'b0);
    check("rr_pending", pending, 8'h21);
    step(8'h21, 1'b1, 1'b1, 1'b0);
    check("rr_first", grant_id, 0);
    step(8'h21, 1'b1, 1'b1, 1'b1);
    run_until_valid(8'h21, 1'b1, 20);
    check("rr_second", grant_id, 5);
    step(8'h21, 1'b1, 1'b1, 1'b0);
    wait_idle(8'h21);
    step(8'h20, 1'b1, 1'b0, 1'b0);
    step(8'h21, 1'b1, 1'b0, 1'b0);
    run_until_valid(8'h21, 1'b0, 10);
    check("rr_third", grant_id, 0);
    step(8'h21, 1'b1, 1'b1, 1'b0);
    wait_idle(8'h21);

    // Back-pressure: grant held 10 cycles, another press only sets pending.
    do_reset(8'h00);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step((i >= 3) ? 8'h44 : 8'h04, 1'b1, 1'b0, 1'b0);
      check("bp_valid", grant_valid, 1);
      check("bp_id", grant_id, 2);
    end
    check("bp_pending", pending, 8'h44);
    step(8'h44, 1'b1, 1'b1, 1'b0);
    check("bp_after_hs", pending, 8'h40);
    wait_idle(8'h44);
    run_until_valid(8'h44, 1'b0, 10);
    check("bp_next", grant_id, 6);
    step(8'h44, 1'b1, 1'b1, 1'b0);
    wait_idle(8'h44);

    // Grant spacing with frame_tick every cycle and instant acceptance.
    do_reset(8'h00);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h03, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!grant_valid && n < 10) begin step(8'h03, 1'b1, 1'b1, 1'b1); n++; end
    check("sp_first", grant_id, 0);
    n = 0;
    do begin step(8'h03, 1'b1, 1'b1, 1'b1); n++; end while (!grant_valid && n < 20);
    check("sp_spacing", n, CD_EN ? CDF + 2 : 2);
    check("sp_second", grant_id, 1);
    wait_idle(8'h03);

    // Reset mid-grant drops the grant and restarts the search at 0.
    do_reset(8'h00);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h10, 1'b1, 1'b0, 1'b0);
    step(8'h10, 1'b1, 1'b0, 1'b0);
    check("mid_valid", grant_valid, 1);
    check("mid_id", grant_id, 4);
    do_reset(8'h10);
    step(8'h10, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h81, 1'b1, 1'b0, 1'b0);
    step(8'h81, 1'b1, 1'b0, 1'b0);
    check("post_rst_valid", grant_valid, 1);
    check("post_rst_id", grant_id, 0);
    step(8'h81, 1'b1, 1'b1, 1'b0);
    wait_idle(8'h81);

    // Randomized traffic against the model.
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 599) == 0) do_reset(r);
      step(r, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 60; c++) step(8'h00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("traffic_seen", obs_grants > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
